// File: rtl/fpu_seq_responder_if.sv
// Request/response port of the sequential FP add/compare responder.
// Signals:
//   req_valid/req_ready  request handshake (issuer -> responder)
//   req_op               [2]=double, [1:0]: 00 add, 01 eq, 10 lt, 11 le
//   req_a/req_b          operands; single precision lives in [63:32]
//   rsp_valid/rsp_ready  response handshake (responder -> writeback)
//   rsp_result           add result (single in [63:32], [31:0]=0); 0 for compares
//   rsp_con              compare outcome; 0 for adds
// Modports: master = issuer/consumer side, slave = the responder.
interface fpu_seq_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic        rsp_con;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_con
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_con
  );
endinterface

// File: rtl/fpu_seq_responder.sv
// Multi-cycle floating-point add/compare responder (single or double precision).
// Operands are unpacked, aligned and normalised iteratively, SHIFT_STEP bits per
// cycle; rounding is truncation. One operation in flight at a time.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any operation in progress
//   bus    fpu_seq_responder_if.slave (request/response handshake + data)
// Parameters:
//   SHIFT_STEP  bits shifted per cycle in ALIGN/NORM (1, 2, 4 or 8)
module fpu_seq_responder #(
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fpu_seq_responder_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, DONE} state_t;

  state_t      state;
  logic [2:0]  lat_op;
  logic [63:0] lat_a, lat_b;
  // Working operands after the swap: A has the larger magnitude.
  // Mantissas carry the hidden bit at [55]; single precision is left-justified
  // so both formats share one datapath, with guard/round/sticky at the bottom.
  logic        s_a, s_b;
  logic [11:0] e_a, e_b;
  logic [55:0] m_a, m_b;
  logic [56:0] sum;

  // Unpack of the latched operands
  logic        dbl;
  logic [11:0] emax, thr;
  logic [11:0] ea_raw, eb_raw, ua_e, ub_e;
  logic [54:0] fa, fb;
  logic [55:0] ua_m, ub_m;
  logic        a_spec, b_spec, a_gt, a_eq, both_zero;
  logic        cmp_eq, cmp_lt, cmp_res;

  always_comb begin
    dbl = lat_op[2];
    if (dbl) begin
      ea_raw = {1'b0, lat_a[62:52]};
      eb_raw = {1'b0, lat_b[62:52]};
      fa     = {lat_a[51:0], 3'b000};
      fb     = {lat_b[51:0], 3'b000};
      emax   = 12'd2047;
      thr    = 12'd56;
    end else begin
      ea_raw = {4'b0000, lat_a[62:55]};
      eb_raw = {4'b0000, lat_b[62:55]};
      fa     = {lat_a[54:32], 32'd0};
      fb     = {lat_b[54:32], 32'd0};
      emax   = 12'd255;
      thr    = 12'd27;
    end
    a_spec = (ea_raw == emax);
    b_spec = (eb_raw == emax);
    // Exponent-zero operands (zero or subnormal) flush to signed zero.
    ua_e = ea_raw;
    ub_e = eb_raw;
    ua_m = (ea_raw == 12'd0) ? '0 : {1'b1, fa};
    ub_m = (eb_raw == 12'd0) ? '0 : {1'b1, fb};
    a_gt = {ua_e, ua_m} > {ub_e, ub_m};
    a_eq = {ua_e, ua_m} == {ub_e, ub_m};
    both_zero = (ua_m == '0) && (ub_m == '0);
    cmp_eq = both_zero || ((lat_a[63] == lat_b[63]) && a_eq);
    if (both_zero)
      cmp_lt = 1'b0;
    else if (lat_a[63] != lat_b[63])
      cmp_lt = lat_a[63];
    else if (!lat_a[63])
      cmp_lt = !a_gt && !a_eq;
    else
      cmp_lt = a_gt;
    case (lat_op[1:0])
      2'b01:   cmp_res = cmp_eq;
      2'b10:   cmp_res = cmp_lt;
      2'b11:   cmp_res = cmp_lt || cmp_eq;
      default: cmp_res = 1'b0;
    endcase
  end

  // One ALIGN step: shift B right, folding shifted-out bits into the sticky bit.
  logic [11:0] diff, al_e;
  logic [55:0] al_m;

  always_comb begin
    diff = e_a - e_b;
    al_m = m_b;
    al_e = e_b;
    if (diff > thr) begin
      al_m = {55'd0, |m_b};
      al_e = e_a;
    end else begin
      for (int unsigned i = 0; i < SHIFT_STEP; i++) begin
        if (al_e != e_a) begin
          al_m = {1'b0, al_m[55:2], al_m[1] | al_m[0]};
          al_e = al_e + 12'd1;
        end
      end
    end
  end

  // One NORM step: left shift until the hidden bit is set or the exponent hits 0.
  logic [55:0] nm;
  logic [11:0] ne, ce;

  always_comb begin
    nm = sum[55:0];
    ne = e_a;
    for (int unsigned i = 0; i < SHIFT_STEP; i++) begin
      if (!nm[55] && (ne != 12'd0)) begin
        nm = {nm[54:0], 1'b0};
        ne = ne - 12'd1;
      end
    end
    ce = e_a + 12'd1;
  end

  function automatic logic [63:0] pack(input logic s, input logic [10:0] e,
                                       input logic [51:0] frac, input logic d);
    if (d)
      return {s, e, frac};
    else
      return {s, e[7:0], frac[51:29], 32'd0};
  endfunction

  logic [63:0] nan_val;
  assign nan_val = dbl ? 64'h7FF8_0000_0000_0000 : 64'h7FC0_0000_0000_0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      lat_op         <= '0;
      lat_a          <= '0;
      lat_b          <= '0;
      s_a            <= 1'b0;
      s_b            <= 1'b0;
      e_a            <= '0;
      e_b            <= '0;
      m_a            <= '0;
      m_b            <= '0;
      sum            <= '0;
      bus.req_ready  <= 1'b1;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_con    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lat_op        <= bus.req_op;
            lat_a         <= bus.req_a;
            lat_b         <= bus.req_b;
            bus.req_ready <= 1'b0;
            state         <= UNPACK;
          end
        end
        UNPACK: begin
          if (lat_op[1:0] != 2'b00) begin
            bus.rsp_con    <= (a_spec || b_spec) ? 1'b0 : cmp_res;
            bus.rsp_result <= '0;
            bus.rsp_valid  <= 1'b1;
            state          <= DONE;
          end else if (a_spec || b_spec) begin
            bus.rsp_con    <= 1'b0;
            bus.rsp_result <= nan_val;
            bus.rsp_valid  <= 1'b1;
            state          <= DONE;
          end else begin
            if (a_gt || a_eq) begin
              s_a <= lat_a[63]; e_a <= ua_e; m_a <= ua_m;
              s_b <= lat_b[63]; e_b <= ub_e; m_b <= ub_m;
            end else begin
              s_a <= lat_b[63]; e_a <= ub_e; m_a <= ub_m;
              s_b <= lat_a[63]; e_b <= ua_e; m_b <= ua_m;
            end
            state <= ALIGN;
          end
        end
        ALIGN: begin
          // The last shift and the move to ADD share a cycle.
          m_b <= al_m;
          e_b <= al_e;
          if (al_e == e_a)
            state <= ADD;
        end
        ADD: begin
          if (s_a ^ s_b)
            sum <= {1'b0, m_a} - {1'b0, m_b};
          else
            sum <= {1'b0, m_a} + {1'b0, m_b};
          state <= NORM;
        end
        NORM: begin
          if (sum == '0) begin
            bus.rsp_result <= '0;
            bus.rsp_con    <= 1'b0;
            bus.rsp_valid  <= 1'b1;
            state          <= DONE;
          end else if (sum[56]) begin
            if (ce >= emax)
              bus.rsp_result <= pack(s_a, emax[10:0], '0, dbl);
            else
              bus.rsp_result <= pack(s_a, ce[10:0], sum[55:4], dbl);
            bus.rsp_con   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            state         <= DONE;
          end else if (ne == 12'd0) begin
            bus.rsp_result <= {s_a, 63'd0};
            bus.rsp_con    <= 1'b0;
            bus.rsp_valid  <= 1'b1;
            state          <= DONE;
          end else if (nm[55]) begin
            bus.rsp_result <= pack(s_a, ne[10:0], nm[54:3], dbl);
            bus.rsp_con    <= 1'b0;
            bus.rsp_valid  <= 1'b1;
            state          <= DONE;
          end else begin
            sum <= {1'b0, nm};
            e_a <= ne;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_seq_responder.sv
// Directed self-checking bench for fpu_seq_responder (SHIFT_STEP=1).
module tb_fpu_seq_responder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fpu_seq_responder_if bus();

  fpu_seq_responder #(.SHIFT_STEP(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request and return #1 after its accept edge; inputs are then
  // scrambled to show the operation uses the latched copy.
  task automatic issue(input string tag, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b);
    @(negedge clk);
    check({tag, "_req_ready"}, bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'($urandom);
    bus.req_a     = {$urandom, $urandom};
    bus.req_b     = {$urandom, $urandom};
  endtask

  // Cycle count includes the accept edge as cycle 1.
  task automatic wait_rsp(input string tag, output int unsigned cyc);
    cyc = 1;
    while (!bus.rsp_valid && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!bus.rsp_valid)
      check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic retire(input string tag);
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check({tag, "_retired_valid"}, bus.rsp_valid, 0);
    check({tag, "_retired_ready"}, bus.req_ready, 1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_res, input logic exp_con);
    int unsigned cyc;
    issue(tag, op, a, b);
    wait_rsp(tag, cyc);
    check({tag, "_result"}, bus.rsp_result, exp_res);
    check({tag, "_con"}, bus.rsp_con, exp_con);
    retire(tag);
  endtask

  initial begin
    int unsigned cyc;
    logic [63:0] held;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_result", bus.rsp_result, 0);
    check("rst_rsp_con", bus.rsp_con, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Additions
    run_op("s_add", 3'b000, 64'h3FA00000_00000000, 64'h3F900000_00000000,
           64'h40180000_00000000, 1'b0);
    run_op("s_cancel", 3'b000, 64'h43CE7E70_00000000, 64'hC3CE7E70_00000000, 64'h0, 1'b0);
    run_op("d_add", 3'b100, 64'h3FF0000000000000, 64'h3FF0000000000000,
           64'h4000000000000000, 1'b0);
    run_op("s_sub_norm", 3'b000, 64'h3F800000_00000000, 64'hBF400000_00000000,
           64'h3E800000_00000000, 1'b0);
    run_op("d_align5", 3'b100, 64'h4000000000000000, 64'h3FB0000000000000,
           64'h4000800000000000, 1'b0);
    run_op("s_far_b", 3'b000, 64'h30800000_00000000, 64'h3F800000_00000000,
           64'h3F800000_00000000, 1'b0);
    run_op("s_ovf", 3'b000, 64'h7F7FFFFF_00000000, 64'h7F7FFFFF_00000000,
           64'h7F800000_00000000, 1'b0);
    run_op("s_nan", 3'b000, 64'h7F800000_00000000, 64'h3F800000_00000000,
           64'h7FC00000_00000000, 1'b0);
    run_op("d_nan", 3'b100, 64'h3FF0000000000000, 64'h7FF0000000000000,
           64'h7FF8000000000000, 1'b0);

    // Compares, with exact compare latency
    issue("d_lt", 3'b110, 64'h41008851FB9E0610, 64'h41008851FB9E0611);
    wait_rsp("d_lt", cyc);
    check("d_lt_latency", 64'(cyc), 2);
    check("d_lt_con", bus.rsp_con, 1);
    check("d_lt_result", bus.rsp_result, 0);
    retire("d_lt");
    run_op("d_lt_swap", 3'b110, 64'h41008851FB9E0611, 64'h41008851FB9E0610, 64'h0, 1'b0);
    run_op("d_le_eq", 3'b111, 64'h41008851FB9E0610, 64'h41008851FB9E0610, 64'h0, 1'b1);
    run_op("d_lt_neg", 3'b110, 64'hBFF0000000000000, 64'h0, 64'h0, 1'b1);
    run_op("d_eq_zero", 3'b101, 64'h0, 64'h8000000000000000, 64'h0, 1'b1);
    run_op("d_eq_nan", 3'b101, 64'h7FF8000000000000, 64'h7FF8000000000000, 64'h0, 1'b0);

    // Back-pressure: response held stable while rsp_ready stays low
    issue("hold", 3'b000, 64'h3FA00000_00000000, 64'h3F900000_00000000);
    wait_rsp("hold", cyc);
    held = bus.rsp_result;
    check("hold_first", held, 64'h40180000_00000000);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_result", bus.rsp_result, held);
      check("hold_valid", bus.rsp_valid, 1);
      check("hold_req_ready", bus.req_ready, 0);
    end
    retire("hold");

    // Reset in the middle of a double-precision ALIGN
    issue("abort", 3'b100, 64'h4000000000000000, 64'h3FB0000000000000);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_rsp_valid", bus.rsp_valid, 0);
    check("abort_req_ready", bus.req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst_eq", 3'b001, 64'h4902B8D9_00000000, 64'h4902B8D9_00000000, 64'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
